// File: rtl/ignore_window_ctrl.sv
// Round-robin arbiter that owns a shared hold-off down-counter for button requesters.
// Optional IGNORE_STATS_EN adds an 8-bit saturating count of dropped presses (ign_cnt).
module ignore_window_ctrl #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] botao,
  input  logic [CNT_W-1:0] preset,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic [CNT_W-1:0] Q,
  output logic             done,
  output logic             ignored
`ifdef IGNORE_STATS_EN
  ,
  output logic [7:0]       ign_cnt
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] botao_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    pick_q, pick_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ignored_q, ignored_d;

  logic [N_REQ-1:0] press, clr, held, avail, drop;
  logic [IW:0]      idx, nxt;
  logic [IW-1:0]    sel;
  logic             found;

  always_comb begin
    press = botao & ~botao_q;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (!found && pending_q[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end

    nxt = {1'b0, pick_q} + (IW+1)'(1);
    if (nxt >= (IW+1)'(N_REQ)) nxt = '0;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    pick_d   = pick_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    clr      = '0;
    done_d   = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          pick_d   = sel;
          clr[sel] = 1'b1;
          grant_d  = N_REQ'(1) << sel;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = preset;
        state_d = (preset == '0) ? DONE : COUNT;
      end
      COUNT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else if (enable) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = nxt[IW-1:0];
        grant_d  = '0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A press on the pick cycle for the picked requester is re-latched.
    held      = (state_q != IDLE) ? grant_q : '0;
    avail     = pending_q & ~clr;
    drop      = press & (held | avail);
    pending_d = avail | (press & ~drop);
    ignored_d = |drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      botao_q   <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      pick_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ignored_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      botao_q   <= botao;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      pick_q    <= pick_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ignored_q <= ignored_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign Q       = cnt_q;
  assign done    = done_q;
  assign ignored = ignored_q;

`ifdef IGNORE_STATS_EN
  logic [7:0] ign_cnt_q, ign_cnt_d;

  always_comb begin
    ign_cnt_d = ign_cnt_q;
    if (ignored_d && ign_cnt_q != 8'hFF) ign_cnt_d = ign_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ign_cnt_q <= '0;
    else       ign_cnt_q <= ign_cnt_d;
  end

  assign ign_cnt = ign_cnt_q;
`endif

endmodule
